// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared opcode/state encodings and default sizing for the multi-cycle control unit.
package multi_cycle_ctrl_pkg;

   localparam int unsigned OPC_W           = 3;
   localparam int unsigned INSTR_W_DEF     = 9;
   localparam int unsigned OPC_MSB         = INSTR_W_DEF - 1;
   localparam int unsigned OPC_LSB         = INSTR_W_DEF - OPC_W;
   localparam int unsigned MEM_TIMEOUT_DEF = 15;
   localparam int unsigned CNT_W_DEF       = 16;

   // aluOp: the opcode field of every instruction word
   typedef enum logic [OPC_W-1:0] {
      ADD  = 3'b000,
      XOR  = 3'b001,
      AND  = 3'b010,
      RSL  = 3'b011,
      MOV  = 3'b100,
      LD   = 3'b101,
      ST   = 3'b110,
      BLQZ = 3'b111
   } aluop_t;

   // Control-unit sequencing states; idle is PC with busy low
   typedef enum logic [1:0] {
      PC            = 2'd0,
      REGISTERREAD  = 2'd1,
      DATAMEM       = 2'd2,
      REGISTERWRITE = 2'd3
   } state_t;

   // Opcodes that need a data-memory transaction
   function automatic logic is_mem_op(input aluop_t op);
      return (op == LD) || (op == ST);
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_mem_wait_timer.sv
// Wait counter for the data-memory handshake: clears, counts on enable, flags the last allowed cycle.
module multi_cycle_ctrl_mem_wait_timer #(
   parameter int unsigned LIMIT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] count;

   // Count wait cycles, holding at the last value so it never wraps
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle control unit: fetch, register read, optional memory access, write-back.
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter int unsigned INSTR_W     = INSTR_W_DEF,
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [INSTR_W-1:0] instr,
   input  logic               prog_end,
   input  logic               br_cond,
   input  logic               mem_ack,
   output logic [1:0]         state_o,
   output logic [INSTR_W-1:0] ir,
   output logic [OPC_W-1:0]   alu_op,
   output logic               ir_load,
   output logic               reg_re,
   output logic               reg_we,
   output logic               mem_re,
   output logic               mem_we,
   output logic               pc_inc,
   output logic               pc_branch,
   output logic               busy,
   output logic               done,
   output logic               mem_timeout,
   output logic [CNT_W-1:0]   instr_count
);

   localparam int unsigned OP_LSB = INSTR_W - OPC_W;
   localparam int unsigned OP_MSB = OP_LSB + OPC_W - 1;

   state_t state;
   aluop_t op;
   logic   retire;
   logic   wait_clear;
   logic   wait_en;
   logic   wait_expired;

   assign alu_op  = ir[OP_MSB:OP_LSB];
   assign op      = aluop_t'(alu_op);
   assign state_o = state;
   assign retire  = pc_inc | pc_branch;

   // The wait count runs only while DATAMEM is waiting for an ack
   assign wait_clear = (state != DATAMEM);
   assign wait_en    = (state == DATAMEM) && !mem_ack;

   multi_cycle_ctrl_mem_wait_timer #(
      .LIMIT (MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (wait_clear),
      .enable  (wait_en),
      .expired (wait_expired)
   );

   // Per-cycle strobes decoded from the current state and the inputs valid in that state
   always_comb begin
      ir_load   = 1'b0;
      reg_re    = 1'b0;
      reg_we    = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      pc_inc    = 1'b0;
      pc_branch = 1'b0;
      if (busy) begin
         case (state)
            PC: begin
               ir_load = !prog_end;
            end
            REGISTERREAD: begin
               reg_re = 1'b1;
               if (op == BLQZ) begin
                  pc_branch = br_cond;
                  pc_inc    = !br_cond;
               end
            end
            DATAMEM: begin
               mem_re = (op == LD);
               mem_we = (op == ST);
               pc_inc = (op == ST) && mem_ack;
            end
            REGISTERWRITE: begin
               reg_we = 1'b1;
               pc_inc = 1'b1;
            end
            default: begin
               ir_load = 1'b0;
            end
         endcase
      end
   end

   // Sequencer: state, instruction register, run/abort status and the retire counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= PC;
         ir          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         mem_timeout <= 1'b0;
         instr_count <= '0;
      end else begin
         done <= 1'b0;
         if (retire && (instr_count != {CNT_W{1'b1}})) begin
            instr_count <= instr_count + CNT_W'(1);
         end
         if (!busy) begin
            if (start) begin
               busy        <= 1'b1;
               state       <= PC;
               mem_timeout <= 1'b0;
               instr_count <= '0;
            end
         end else begin
            case (state)
               PC: begin
                  if (prog_end) begin
                     busy <= 1'b0;
                     done <= 1'b1;
                  end else begin
                     ir    <= instr;
                     state <= REGISTERREAD;
                  end
               end
               REGISTERREAD: begin
                  if (op == BLQZ) begin
                     state <= PC;
                  end else if (is_mem_op(op)) begin
                     state <= DATAMEM;
                  end else begin
                     state <= REGISTERWRITE;
                  end
               end
               DATAMEM: begin
                  // An ack on the last allowed cycle still completes the access
                  if (mem_ack) begin
                     state <= (op == LD) ? REGISTERWRITE : PC;
                  end else if (wait_expired) begin
                     state       <= PC;
                     busy        <= 1'b0;
                     mem_timeout <= 1'b1;
                  end
               end
               REGISTERWRITE: begin
                  state <= PC;
               end
               default: begin
                  state <= PC;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: a fetch/memory environment runs programs while a monitor checks events.
module tb_multi_cycle_ctrl;
   import multi_cycle_ctrl_pkg::*;

   localparam int TO = 15;
   localparam int K_INC  = 0;
   localparam int K_BR   = 1;
   localparam int K_DONE = 2;
   localparam int K_TO   = 3;

   logic        clk = 1'b0;
   logic        reset, start, prog_end, br_cond, mem_ack;
   logic [8:0]  instr;
   logic [1:0]  state_o;
   logic [8:0]  ir;
   logic [2:0]  alu_op;
   logic        ir_load, reg_re, reg_we, mem_re, mem_we, pc_inc, pc_branch;
   logic        busy, done, mem_timeout;
   logic [15:0] instr_count;

   multi_cycle_ctrl #(.INSTR_W(9), .MEM_TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .instr(instr), .prog_end(prog_end),
      .br_cond(br_cond), .mem_ack(mem_ack), .state_o(state_o), .ir(ir), .alu_op(alu_op),
      .ir_load(ir_load), .reg_re(reg_re), .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we),
      .pc_inc(pc_inc), .pc_branch(pc_branch), .busy(busy), .done(done),
      .mem_timeout(mem_timeout), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [8:0] word; bit br; int w; } ins_t;
   typedef struct { int kind; int lat; bit rwe; int mcyc; logic [2:0] op; int cnt; } exp_t;

   ins_t prog[$];
   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   env_pc = 0;
   int   dm_cnt = 0;
   bit   mon_en = 1'b0;
   int   lat = 0;
   int   mcyc = 0;
   int   loads = 0;
   logic prev_to = 1'b0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic add(input logic [8:0] word, input bit br, input int w);
      ins_t x;
      x.word = word; x.br = br; x.w = w;
      prog.push_back(x);
   endtask

   // Environment bookkeeping: PC advances on retire; count cycles already spent in DATAMEM
   always @(negedge clk) begin
      if (pc_inc || pc_branch) env_pc++;
      if (state_o == 2'(DATAMEM)) dm_cnt++;
      else dm_cnt = 0;
   end

   // Environment drive: fetch word, branch condition, memory ack after w wait cycles (noise elsewhere)
   always @(posedge clk) begin
      #1;
      if (env_pc < prog.size()) begin
         instr = prog[env_pc].word; br_cond = prog[env_pc].br; prog_end = 1'b0;
      end else begin
         instr = 9'($urandom); br_cond = 1'($urandom); prog_end = 1'b1;
      end
      if (state_o == 2'(DATAMEM) && env_pc < prog.size()) mem_ack = (dm_cnt == prog[env_pc].w);
      else mem_ack = 1'($urandom);
   end

   // Monitor: pops the scoreboard on every retire, done pulse or timeout abort
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         chk("strobe_exclusion", 32'({mem_re & mem_we, reg_we & mem_we, pc_inc & pc_branch}), 0);
         if (ir_load) begin lat = 1; mcyc = 0; loads++; end
         else lat++;
         if (mem_re || mem_we) mcyc++;
         if (pc_inc || pc_branch) begin
            if (sb.size() == 0) chk("unexpected_retire", 32'(pc_inc), 0);
            else begin
               e = sb.pop_front();
               chk("retire_kind", pc_branch ? K_BR : K_INC, e.kind);
               chk("retire_latency", lat, e.lat);
               chk("retire_reg_we", 32'(reg_we), 32'(e.rwe));
               chk("retire_mem_cycles", mcyc, e.mcyc);
               chk("retire_alu_op", 32'(alu_op), 32'(e.op));
               chk("retire_count_before", 32'(instr_count), e.cnt);
            end
         end
         if (done) begin
            if (sb.size() == 0) chk("unexpected_done", 32'(done), 0);
            else begin
               e = sb.pop_front();
               chk("done_kind", K_DONE, e.kind);
               chk("done_busy", 32'(busy), 0);
               chk("done_count", 32'(instr_count), e.cnt);
            end
         end
         if (mem_timeout && !prev_to) begin
            if (sb.size() == 0) chk("unexpected_timeout", 32'(mem_timeout), 0);
            else begin
               e = sb.pop_front();
               chk("timeout_kind", K_TO, e.kind);
               chk("timeout_mem_cycles", mcyc, e.mcyc);
               chk("timeout_busy", 32'(busy), 0);
               chk("timeout_count", 32'(instr_count), e.cnt);
            end
         end
      end
      prev_to = mem_timeout;
   end

   // Build expectations for the current program from the timing rules, then run it
   task automatic run_prog();
      exp_t e;
      int   cnt = 0;
      int   fetch = 0;
      bit   ab = 1'b0;
      int   guard = 0;
      logic [8:0] wd;
      logic [2:0] op;
      foreach (prog[i]) begin
         if (!ab) begin
            wd = prog[i].word;
            op = wd[OPC_MSB:OPC_LSB];
            fetch++;
            e.op = op; e.cnt = cnt; e.lat = 0; e.rwe = 1'b0; e.mcyc = 0;
            if (op == 3'(BLQZ)) begin
               e.kind = prog[i].br ? K_BR : K_INC; e.lat = 2;
            end else if (op == 3'(LD) || op == 3'(ST)) begin
               if (prog[i].w >= TO) begin
                  e.kind = K_TO; e.mcyc = TO; ab = 1'b1;
               end else begin
                  e.kind = K_INC;
                  e.mcyc = prog[i].w + 1;
                  e.lat  = ((op == 3'(LD)) ? 4 : 3) + prog[i].w;
                  e.rwe  = (op == 3'(LD));
               end
            end else begin
               e.kind = K_INC; e.lat = 3; e.rwe = 1'b1;
            end
            sb.push_back(e);
            if (!ab) cnt++;
         end
      end
      if (!ab) begin
         e.kind = K_DONE; e.cnt = cnt; e.lat = 0; e.rwe = 1'b0; e.mcyc = 0; e.op = 3'd0;
         sb.push_back(e);
      end
      @(negedge clk);
      env_pc = 0;
      loads  = 0;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'($urandom);
      @(negedge clk);
      chk("start_busy", 32'(busy), 1);
      chk("start_clears_timeout", 32'(mem_timeout), 0);
      chk("start_clears_count", 32'(instr_count), 0);
      while (busy === 1'b1 && guard < 3000) begin
         @(posedge clk); #1;
         start = busy ? 1'($urandom) : 1'b0;
         guard++;
      end
      start = 1'b0;
      @(negedge clk); #1;
      chk("run_finished", 32'(busy), 0);
      chk("fetch_count", loads, fetch);
      chk("scoreboard_drained", sb.size(), 0);
      chk("final_count", 32'(instr_count), cnt);
      chk("final_timeout_flag", 32'(mem_timeout), 32'(ab));
      sb.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int guard;
      int n;
      int r;
      logic [2:0] op;
      reset = 1'b1; start = 1'b0; instr = '0; prog_end = 1'b0; br_cond = 1'b0; mem_ack = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(state_o), 0);
      chk("reset_ir", 32'(ir), 0);
      chk("reset_alu_op", 32'(alu_op), 32'(ADD));
      chk("reset_busy", 32'(busy), 0);
      chk("reset_done", 32'(done), 0);
      chk("reset_timeout", 32'(mem_timeout), 0);
      chk("reset_count", 32'(instr_count), 0);
      chk("reset_strobes", 32'({ir_load, reg_re, reg_we, mem_re, mem_we, pc_inc, pc_branch}), 0);
      @(posedge clk); #1; reset = 1'b0;
      mon_en = 1'b1;

      prog.delete(); add(9'b000_000001, 1'b0, 0);                            run_prog();
      prog.delete(); add(9'b101_000010, 1'b0, 2);                            run_prog();
      prog.delete(); add(9'b111_000011, 1'b1, 0); add(9'b111_000011, 1'b0, 0); run_prog();
      prog.delete(); add(9'b110_000100, 1'b0, 99);                           run_prog();
      prog.delete();                                                          run_prog();
      prog.delete(); add(9'b101_000001, 1'b0, 14); add(9'b110_000001, 1'b0, 0);
                     add(9'b011_000001, 1'b0, 0);  add(9'b100_000001, 1'b0, 0); run_prog();
      prog.delete(); add(9'b001_000001, 1'b0, 0);  add(9'b101_000111, 1'b0, 15); run_prog();

      for (int k = 0; k < 40; k++) begin
         prog.delete();
         n = $urandom_range(1, 8);
         for (int i = 0; i < n; i++) begin
            op = 3'($urandom_range(0, 7));
            r  = $urandom_range(0, 9);
            add({op, 6'($urandom)}, 1'($urandom), (r == 0) ? $urandom_range(15, 18) : $urandom_range(0, 14));
         end
         run_prog();
      end

      // Reset in the second DATAMEM cycle of a load that never gets an ack
      mon_en = 1'b0;
      prog.delete(); add(9'b000_000001, 1'b0, 0); add(9'b101_000010, 1'b0, 99);
      @(negedge clk); env_pc = 0;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      guard = 0;
      while (state_o !== 2'(DATAMEM) && guard < 100) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_mem_re_before", 32'(mem_re), 1);
      chk("rst_mid_count_before", 32'(instr_count), 1);
      @(posedge clk); #1; reset = 1'b0;
      @(negedge clk);
      chk("rst_mid_strobes", 32'({ir_load, reg_re, reg_we, mem_re, mem_we, pc_inc, pc_branch}), 0);
      chk("rst_mid_state", 32'(state_o), 0);
      chk("rst_mid_busy", 32'(busy), 0);
      chk("rst_mid_count", 32'(instr_count), 0);
      chk("rst_mid_done", 32'(done), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
Multi-cycle control unit that consumes the shared aluOp opcode and state encodings. It fetches a 9-bit instruction, decodes opcode bits [8:6], and sequences the PC -> REGISTERREAD -> DATAMEM -> REGISTERWRITE states. It drives register-file, data-memory and PC strobes, and runs a ready/ack handshake with data memory.

Parameters:
INSTR_W, 9, instruction width; opcode is always bits [INSTR_W-1:INSTR_W-3]
MEM_TIMEOUT, 15, maximum DATAMEM cycles waiting for mem_ack before abort
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  begin execution from idle; ignored while busy
instr  in  INSTR_W  instruction word at current PC, valid in PC state
prog_end  in  1  fetch unit flag: current PC is past the last instruction
br_cond  in  1  BLQZ condition (register value <= 0), valid in REGISTERREAD
mem_ack  in  1  data memory completes the current read/write this cycle
state_o  out  2  current state (state enum)
ir  out  INSTR_W  latched instruction register
alu_op  out  3  ir opcode field as aluOp
ir_load  out  1  IR capture strobe
reg_re  out  1  register-file read enable
reg_we  out  1  register-file write enable
mem_re  out  1  data-memory read request
mem_we  out  1  data-memory write request
pc_inc  out  1  PC += 1 pulse
pc_branch  out  1  PC <= branch target pulse
busy  out  1  executing
done  out  1  one-cycle pulse on normal program end
mem_timeout  out  1  sticky memory-handshake abort flag
instr_count  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (synchronous, active-high) drives: state_o=PC, ir=0, alu_op=ADD, busy=0, done=0, mem_timeout=0, instr_count=0, and every strobe 0. Reset applied mid-DATAMEM drops mem_re/mem_we on the next edge with no retire.
- Idle: busy=0 and state_o=PC. When start=1, the next cycle has busy=1. The same start edge clears mem_timeout and instr_count.
- PC state (busy=1):
  - If prog_end=1: no fetch; done pulses 1 cycle; busy=0; return to idle.
  - Otherwise: ir_load=1; ir<=instr; next state is REGISTERREAD.
- REGISTERREAD: reg_re=1 for 1 cycle. Next state by opcode:
  - ADD/XOR/AND/RSL/MOV -> REGISTERWRITE.
  - LD/ST -> DATAMEM.
  - BLQZ -> retire here. pc_branch=1 if br_cond=1, else pc_inc=1. Next state is PC.
- DATAMEM:
  - mem_re (LD) or mem_we (ST) is held high every cycle until mem_ack is sampled 1, inclusive. Zero wait is allowed: ack in the first DATAMEM cycle is legal.
  - On ack: LD -> REGISTERWRITE; ST retires (pc_inc=1) -> PC.
  - A wait counter starts at 0 on entry and increments each cycle without ack. If the count reaches MEM_TIMEOUT-1 with no ack:
    - strobes drop, mem_timeout<=1, busy<=0, return to idle;
    - no pc_inc, and instr_count is unchanged.
- REGISTERWRITE: reg_we=1 and pc_inc=1 in the same cycle (retire); next state is PC.
- Retire: exactly one of pc_inc/pc_branch pulses. instr_count increments, saturating at 2^CNT_W-1.
- Cycle latencies from ir_load:
  - ALU ops: 3 cycles.
  - BLQZ: 2 cycles.
  - LD: 4 + waits.
  - ST: 3 + waits.
- mem_ack outside DATAMEM is ignored. start while busy is ignored.
- alu_op is combinational from ir[8:6] and is stable through the whole instruction.
- Never asserted together: mem_re and mem_we; reg_we and mem_we; pc_inc and pc_branch.

Decomposition:
- Shared definitions package: reuse the existing aluOp and state enums. Add the INSTR_W default, the opcode field MSB/LSB constants, and the MEM_TIMEOUT default.
- One sub-module, mem_wait_timer: a counter with clear, enable and an expired output, instantiated for the DATAMEM wait.

Test Plan:
- reset, start, instr=9'b000_000001 (ADD), prog_end=0 -> ir_load at cycle 1, reg_re at 2, reg_we+pc_inc at 3, instr_count=1.
- LD instr=9'b101_000010, mem_ack asserted on the 3rd DATAMEM cycle -> mem_re high exactly 3 cycles, then reg_we+pc_inc, instr_count+1.
- BLQZ instr=9'b111_000011, once with br_cond=1 and once with br_cond=0 -> pc_branch=1 and pc_inc=1 respectively, in REGISTERREAD, with no reg_we or mem strobes.
- ST with mem_ack held 0 -> mem_we high for 15 cycles, then mem_timeout=1, busy=0, instr_count unchanged; a following start clears mem_timeout.
- prog_end=1 in the first PC state after start -> done pulse 1 cycle, busy=0, no ir_load.
- reset asserted during the 2nd DATAMEM cycle of LD -> next cycle: all strobes 0, state_o=PC, busy=0, instr_count=0.
